rad4_booth_mult_hs: RTL and testbench
=====================================

Name: rad4_booth_mult_hs

Overview:
Sequential radix-4 Booth multiplier and successor to the fixed unsigned radix-4 multiplier. It adds a per-operation signed/unsigned mode and a configurable number of Booth digits retired per clock. A valid/ready handshake replaces the external done strobe. It sits as a multicycle arithmetic unit between an operand producer and a result consumer, and holds one operation in flight.

Parameters:
DIGITS, 256, radix-4 digits per operand; operand width W = 2*DIGITS bits; must be ≥ 2.
DPC, 1, Booth digits retired per CALC cycle; legal values 1, 2, 4; elaboration error otherwise.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset; sampled on rising clk edge
x  in  2*DIGITS  multiplicand; sampled on accept edge
y  in  2*DIGITS  multiplier; sampled on accept edge
tc  in  1  1 = two's-complement operands, 0 = unsigned; sampled on accept edge
start  in  1  operation request
in_ready  out  1  high only in IDLE
out  out  4*DIGITS  product; stable while out_valid
out_valid  out  1  result available
out_ready  in  1  consumer accepts result

Behaviour:
- One clock (clk). Reset is synchronous and active-low on port reset.
- reset=0 at an edge forces the following, regardless of state, including mid-CALC or DONE:
  - state IDLE
  - out=0, out_valid=0, in_ready=1
  - internal accumulator, multiplier register and digit counter cleared
- The in-flight operation is discarded with no partial result.
- States:
  - IDLE: in_ready=1. On start=1, x, y and tc are latched and the state goes to CALC. start in any other state is ignored; no queueing.
  - CALC: in_ready=0, out_valid=0. Each edge recodes DPC Booth digits from the multiplier, lowest first. Each digit selects {0, ±X, ±2X}, shifted by 2*i. Let ND = DIGITS when tc=1, or DIGITS+1 when tc=0 (the extra digit absorbs the unsigned MSB). After N = ceil(ND/DPC) CALC edges, out is loaded and the state goes to DONE.
  - DONE: out_valid=1; out holds. When out_valid && out_ready at an edge, the state goes to IDLE and out_valid=0. out keeps its last value until the next result load.
- Latency: out_valid is first high in the cycle after the N-th edge following the accept edge. Throughput is one op per N+2 cycles with out_ready tied high.
- Recoding:
  - Multiplier register is extended with an implicit 0 below bit 0.
  - For tc=0, zero-extended by 2 bits above the MSB.
  - For tc=1, sign-extended.
  - Digits beyond ND when DPC does not divide ND are treated as 0.
- Arithmetic:
  - X is sign-extended (tc=1) or zero-extended (tc=0) to the internal accumulator width of 4*DIGITS+2.
  - out = low 4*DIGITS bits of the exact product; no overflow is possible.
  - tc=1 produces a two's-complement product.
- Corner cases:
  - tc=1, x=y=−2^(W−1) → out=2^(2W−2), which must be correct.
  - x=0 or y=0 still takes the full N cycles; no early exit.
- start held high through DONE→IDLE is accepted again on the first IDLE edge.

Test Plan:
- DIGITS=4, DPC=1, reset low 2 edges then high. Drive tc=0, x=255, y=255, start pulse 1 cycle → out_valid after exactly 5 edges, out=65025 (0xFE01); in_ready=0 throughout CALC/DONE.
- DIGITS=4, DPC=1, tc=1, x=0x80, y=0x80 → out=0x4000 after 4 edges. Next op tc=1, x=0xFF, y=0x01 → out=0xFFFF.
- DIGITS=4, DPC=2: tc=0, x=200, y=3 → out=600 after 3 edges. tc=1, x=0x9C (−100), y=0x05 → out=0xFE0C (−500) after 2 edges.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid → out and out_valid stable. start=1 during DONE is ignored. out_ready=1 → IDLE next edge, then start accepted.
- Reset mid-op: drive reset=0 on the 2nd CALC edge → next cycle out_valid=0, out=0, in_ready=1. A new op (tc=0, x=7, y=9) yields 63 with normal latency.
- Randomized self-check at DIGITS=8 with DPC ∈ {1,2,4} and both tc values, ≥1000 ops each, with random out_ready → every out equals the reference product; latency = ceil(ND/DPC) edges.

Source files
------------

// File: rtl/rad4_booth_mult_hs.sv
// Sequential radix-4 Booth multiplier with per-operation signed/unsigned mode,
// DPC Booth digits retired per clock and valid/ready handshakes on both sides.
// One operation is held in flight: IDLE accepts, CALC accumulates, DONE holds
// the product until the consumer takes it.
module rad4_booth_mult_hs #(
    parameter int DIGITS = 256,
    parameter int DPC    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*DIGITS-1:0]   x,
    input  logic [2*DIGITS-1:0]   y,
    input  logic                  tc,
    input  logic                  start,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Operand width, accumulator width (two guard bits above the product),
    // multiplier window width (implicit zero below bit 0 plus 2*DPC extension
    // bits on top so every digit window of the last cycle stays in range),
    // and digit counter width with headroom for the overshoot past ND.
    localparam int W  = 2 * DIGITS;
    localparam int AW = 2 * W + 2;
    localparam int MW = W + 2 * DPC + 1;
    localparam int CW = $clog2(DIGITS + DPC + 2) + 1;

    // Illegal configurations stop elaboration.
    if (DPC != 1 && DPC != 2 && DPC != 4) begin : g_bad_dpc
        $error("rad4_booth_mult_hs: DPC must be 1, 2 or 4");
    end
    if (DIGITS < 2) begin : g_bad_digits
        $error("rad4_booth_mult_hs: DIGITS must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q,   acc_d;
    logic [AW-1:0]   xe_q,    xe_d;
    logic [MW-1:0]   m_q,     m_d;
    logic [CW-1:0]   dig_q,   dig_d;
    logic            tc_q,    tc_d;
    logic [W*2-1:0]  out_q,   out_d;

    logic [CW-1:0]   nd;
    logic [AW-1:0]   calc_sum;

    // Booth partial product for one digit window {b(2i+1), b(2i), b(2i-1)}:
    // selects 0, +X, +2X, -2X or -X, all modulo the accumulator width.
    function automatic logic [AW-1:0] booth_pp(input logic [2:0] trip,
                                               input logic [AW-1:0] mcand);
        logic [AW-1:0] pp;
        case (trip)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        return pp;
    endfunction

    // Unsigned operands need one extra digit to absorb the multiplier MSB.
    assign nd = tc_q ? CW'(DIGITS) : CW'(DIGITS + 1);

    // Sum of this cycle's DPC digits onto the accumulator; digits at or beyond
    // ND contribute nothing, which covers DPC not dividing ND.
    always_comb begin
        calc_sum = acc_q;
        for (int j = 0; j < DPC; j++) begin
            if ((dig_q + CW'(j)) < nd) begin
                calc_sum = calc_sum + (booth_pp(m_q[2*j +: 3], xe_q) << (2 * j));
            end
        end
    end

    // Next-state and datapath control: latch operands on accept, retire DPC
    // digits per CALC cycle, load the result on the last one, hand it off in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        xe_d    = xe_q;
        m_d     = m_q;
        dig_d   = dig_q;
        tc_d    = tc_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xe_d    = {{(AW - W){tc & x[W-1]}}, x};
                    m_d     = {{(MW - W - 1){tc & y[W-1]}}, y, 1'b0};
                    acc_d   = '0;
                    dig_d   = '0;
                    tc_d    = tc;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = calc_sum;
                xe_d  = xe_q << (2 * DPC);
                m_d   = {{(2 * DPC){m_q[MW-1]}}, m_q[MW-1:2*DPC]};
                dig_d = dig_q + CW'(DPC);
                if ((dig_q + CW'(DPC)) >= nd) begin
                    out_d   = calc_sum[2*W-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; a low reset at any edge abandons the operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            xe_q    <= '0;
            m_q     <= '0;
            dig_q   <= '0;
            tc_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            xe_q    <= xe_d;
            m_q     <= m_d;
            dig_q   <= dig_d;
            tc_q    <= tc_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;

endmodule

// File: tb/tb_rad4_booth_mult_hs.sv
// Self-checking bench: three multipliers (DIGITS=4, DPC=1/2/4) share one set of
// inputs; a cycle-level reference model per instance is compared on every cycle,
// and directed operations are pinned to hand-computed products and latencies.
module tb_rad4_booth_mult_hs;

   localparam int DIG = 4;
   localparam int W   = 2 * DIG;
   localparam int PW  = 4 * DIG;

   logic          clk = 1'b0;
   logic          reset;
   logic          tc;
   logic          start;
   logic          out_ready;
   logic [W-1:0]  x;
   logic [W-1:0]  y;

   logic [PW-1:0] o1, o2, o4;
   logic          v1, v2, v4;
   logic          r1, r2, r4;

   logic [PW-1:0] dout [3];
   logic          dval [3];
   logic          drdy [3];

   int total = 0;
   int bad   = 0;
   bit chkEn = 1'b0;

   typedef enum {M_IDLE, M_BUSY, M_DONE} mstate_t;
   mstate_t       mst  [3];
   int            mcnt [3];
   logic [PW-1:0] mexp [3];
   logic [PW-1:0] mout [3];

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   rad4_booth_mult_hs #(.DIGITS(DIG), .DPC(1)) u_dpc1 (
      .clk(clk), .reset(reset), .x(x), .y(y), .tc(tc), .start(start),
      .in_ready(r1), .out(o1), .out_valid(v1), .out_ready(out_ready));
   rad4_booth_mult_hs #(.DIGITS(DIG), .DPC(2)) u_dpc2 (
      .clk(clk), .reset(reset), .x(x), .y(y), .tc(tc), .start(start),
      .in_ready(r2), .out(o2), .out_valid(v2), .out_ready(out_ready));
   rad4_booth_mult_hs #(.DIGITS(DIG), .DPC(4)) u_dpc4 (
      .clk(clk), .reset(reset), .x(x), .y(y), .tc(tc), .start(start),
      .in_ready(r4), .out(o4), .out_valid(v4), .out_ready(out_ready));

   assign dout[0] = o1;
   assign dout[1] = o2;
   assign dout[2] = o4;
   assign dval[0] = v1;
   assign dval[1] = v2;
   assign dval[2] = v4;
   assign drdy[0] = r1;
   assign drdy[1] = r2;
   assign drdy[2] = r4;

   function automatic int dpcOf(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
   endfunction

   // Edges spent in CALC: ceil(ND/DPC) with ND one larger for unsigned.
   function automatic int nCycles(input int dpc, input logic t);
      int nd;
      nd = t ? DIG : DIG + 1;
      return (nd + dpc - 1) / dpc;
   endfunction

   // Exact product by plain integer arithmetic, truncated to the output width.
   function automatic logic [PW-1:0] refProd(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic t);
      longint sa;
      longint sb;
      if (t) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      return PW'(sa * sb);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: idle/busy/done per instance, busy for ceil(ND/DPC)
   // edges after the accept edge, then the arithmetic product is presented
   // and held until the consumer is ready.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!reset) begin
            mst[i]  <= M_IDLE;
            mcnt[i] <= 0;
            mout[i] <= '0;
         end else begin
            case (mst[i])
               M_IDLE: if (start) begin
                  mst[i]  <= M_BUSY;
                  mcnt[i] <= nCycles(dpcOf(i), tc);
                  mexp[i] <= refProd(x, y, tc);
               end
               M_BUSY: begin
                  if (mcnt[i] == 1) begin
                     mst[i]  <= M_DONE;
                     mout[i] <= mexp[i];
                  end
                  mcnt[i] <= mcnt[i] - 1;
               end
               M_DONE: if (out_ready) mst[i] <= M_IDLE;
               default: mst[i] <= M_IDLE;
            endcase
         end
      end
   end

   // Every-cycle comparison of all three instances against the model,
   // sampled on the falling edge away from the active edge.
   always @(negedge clk) begin
      if (chkEn) begin
         for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("model_out_dpc%0d", dpcOf(i)), 32'(dout[i]), 32'(mout[i]));
            checkOutput($sformatf("model_valid_dpc%0d", dpcOf(i)), 32'(dval[i]),
                        32'(mst[i] == M_DONE));
            checkOutput($sformatf("model_inready_dpc%0d", dpcOf(i)), 32'(drdy[i]),
                        32'(mst[i] == M_IDLE));
         end
      end
   end

   // Present one operation, hold start for the accept edge, then drop it
   // and confirm every instance has left IDLE.
   task automatic launchOp(input logic t, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      tc    = t;
      x     = a;
      y     = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("inready_busy_dpc%0d", dpcOf(i)), 32'(drdy[i]), 32'd0);
   endtask

   // Count edges from the accept edge until each instance raises out_valid,
   // bounded, then check product and latency against the given expectations.
   task automatic collectResults(input string name, input logic [PW-1:0] exp,
                                 input int l1, input int l2, input int l4);
      int            lat  [3];
      logic [PW-1:0] got  [3];
      bit            seen [3];
      int            want [3];
      int            k;
      want = '{l1, l2, l4};
      seen = '{1'b0, 1'b0, 1'b0};
      k = 0;
      while (!(seen[0] && seen[1] && seen[2]) && k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (!seen[i] && dval[i]) begin
               seen[i] = 1'b1;
               lat[i]  = k;
               got[i]  = dout[i];
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (!seen[i]) begin
            checkOutput($sformatf("%s_timeout_dpc%0d", name, dpcOf(i)), 32'd0, 32'd1);
         end else begin
            checkOutput($sformatf("%s_prod_dpc%0d", name, dpcOf(i)), 32'(got[i]), 32'(exp));
            checkOutput($sformatf("%s_lat_dpc%0d", name, dpcOf(i)), 32'(lat[i]), 32'(want[i]));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input string name, input logic t,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [PW-1:0] exp,
                                input int l1, input int l2, input int l4);
      launchOp(t, a, b);
      collectResults(name, exp, l1, l2, l4);
   endtask

   // Main sequence: reset, directed products, backpressure, reset mid-op,
   // a corner-value sweep and a free-running random handshake phase.
   initial begin : main
      logic [W-1:0] cv [7];
      int k;
      cv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA};
      reset     = 1'b0;
      start     = 1'b0;
      tc        = 1'b0;
      x         = '0;
      y         = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chkEn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("reset_inready_dpc%0d", dpcOf(i)), 32'(drdy[i]), 32'd1);
         checkOutput($sformatf("reset_valid_dpc%0d", dpcOf(i)), 32'(dval[i]), 32'd0);
         checkOutput($sformatf("reset_out_dpc%0d", dpcOf(i)), 32'(dout[i]), 32'd0);
      end
      reset = 1'b1;

      applyStimulus("u255x255",  1'b0, 8'hFF, 8'hFF, 16'hFE01, 5, 3, 2);
      applyStimulus("s80x80",    1'b1, 8'h80, 8'h80, 16'h4000, 4, 2, 1);
      applyStimulus("sFFx01",    1'b1, 8'hFF, 8'h01, 16'hFFFF, 4, 2, 1);
      applyStimulus("u200x3",    1'b0, 8'd200, 8'd3, 16'h0258, 5, 3, 2);
      applyStimulus("s9Cx05",    1'b1, 8'h9C, 8'h05, 16'hFE0C, 4, 2, 1);
      applyStimulus("u0x55",     1'b0, 8'h00, 8'h55, 16'h0000, 5, 3, 2);
      applyStimulus("s7Fx80",    1'b1, 8'h7F, 8'h80, 16'hC080, 4, 2, 1);
      applyStimulus("u80x80",    1'b0, 8'h80, 8'h80, 16'h4000, 5, 3, 2);

      // Backpressure: result must hold while out_ready is low, start ignored.
      out_ready = 1'b0;
      launchOp(1'b0, 8'd200, 8'd3);
      k = 0;
      while (!(dval[0] && dval[1] && dval[2]) && k < 20) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      checkOutput("bp_all_valid", 32'(dval[0] && dval[1] && dval[2]), 32'd1);
      for (int c = 0; c < 6; c++) begin
         start = 1'b1;
         x     = 8'h11;
         y     = 8'h22;
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp_hold_valid_dpc%0d", dpcOf(i)), 32'(dval[i]), 32'd1);
            checkOutput($sformatf("bp_hold_out_dpc%0d", dpcOf(i)), 32'(dout[i]), 32'd600);
         end
      end
      out_ready = 1'b1;
      x         = 8'd12;
      y         = 8'd13;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("bp_release_idle_dpc%0d", dpcOf(i)), 32'(drdy[i]), 32'd1);
         checkOutput($sformatf("bp_release_valid_dpc%0d", dpcOf(i)), 32'(dval[i]), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("bp_reaccept_dpc%0d", dpcOf(i)), 32'(drdy[i]), 32'd0);
      collectResults("u12x13", 16'd156, 5, 3, 2);

      // Reset asserted on the second CALC edge discards the operation.
      launchOp(1'b0, 8'd100, 8'd100);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("midreset_valid_dpc%0d", dpcOf(i)), 32'(dval[i]), 32'd0);
         checkOutput($sformatf("midreset_out_dpc%0d", dpcOf(i)), 32'(dout[i]), 32'd0);
         checkOutput($sformatf("midreset_inready_dpc%0d", dpcOf(i)), 32'(drdy[i]), 32'd1);
      end
      reset = 1'b1;
      applyStimulus("u7x9", 1'b0, 8'd7, 8'd9, 16'd63, 5, 3, 2);

      // Corner-value sweep in both modes, expectations from the model.
      for (int a = 0; a < 7; a++) begin
         for (int b = 0; b < 7; b++) begin
            for (int t = 0; t < 2; t++) begin
               applyStimulus("sweep", t[0], cv[a], cv[b], refProd(cv[a], cv[b], t[0]),
                             nCycles(1, t[0]), nCycles(2, t[0]), nCycles(4, t[0]));
            end
         end
      end

      // Free-running phase: random operands, start and consumer readiness;
      // the instances drift apart and the model tracks each one.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start     = ($urandom_range(0, 2) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tc        = $urandom_range(0, 1) == 1;
         x         = W'($urandom);
         y         = W'($urandom);
      end
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("drain_idle_dpc%0d", dpcOf(i)), 32'(drdy[i]), 32'd1);

      chkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
